// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified memory port arbiter.
// Used by mem_port_arbiter and its bus interface.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam logic [127:0] ARB_BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// master: arbiter view; slave: environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              flush;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, flush,
    input  d_req, d_we, d_addr,
    input  d_wdata, d_be,
    input  mem_ack, mem_rdata,
    output if_rdata, if_valid, if_stall,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr, flush,
    output d_req, d_we, d_addr,
    output d_wdata, d_be,
    output mem_ack, mem_rdata,
    input  if_rdata, if_valid, if_stall,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch vs load/store) for one memory port.
// Define ARB_FAIR_EN to bound consecutive data grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;

  logic              drop_q, drop_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [BE_W-1:0]   mbe_q, mbe_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic              iv_q, iv_d;
  logic              dv_q, dv_d;

  logic idle;
  logic fetch_ok;
  logic fair_force;
  logic gnt_d;
  logic gnt_f;

  assign idle     = (state_q == IDLE);
  assign fetch_ok = bus.if_req & ~bus.flush;
  assign gnt_d    = idle & bus.d_req
                  & ~(fair_force & fetch_ok);
  assign gnt_f    = idle & fetch_ok & ~gnt_d;

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  assign fair_force = (streak_q == SMAX);

  always_comb begin
    streak_d = streak_q;
    if (idle) begin
      if (gnt_f || !bus.if_req)
        streak_d = '0;
      else if (gnt_d && streak_q != SMAX)
        streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end
`else
  logic unused_max;
  assign unused_max = ^MAX_D_STREAK;
  assign fair_force = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d)      state_d = DATA;
        else if (gnt_f) state_d = FETCH;
      end
      FETCH, DATA: begin
        if (bus.mem_ack) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    drop_d   = drop_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    ird_d    = ird_q;
    drd_d    = drd_q;
    iv_d     = 1'b0;
    dv_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          owner_d  = OWN_D;
          mreq_d   = 1'b1;
          mwe_d    = bus.d_we;
          maddr_d  = bus.d_addr;
          mwdata_d = bus.d_wdata;
          mbe_d    = bus.d_be;
        end else if (gnt_f) begin
          owner_d  = OWN_IF;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = bus.if_addr;
          mwdata_d = '0;
          mbe_d    = ARB_BE_ALL[BE_W-1:0];
        end
      end
      FETCH, DATA: begin
        if (owner_q == OWN_IF && bus.flush)
          drop_d = 1'b1;
        if (bus.mem_ack) begin
          mreq_d = 1'b0;
          if (owner_q == OWN_IF) begin
            ird_d = bus.mem_rdata;
            // A flush landing on the ack cycle still kills the fetch.
            iv_d  = ~drop_q & ~bus.flush;
          end else begin
            drd_d = bus.mem_rdata;
            dv_d  = 1'b1;
          end
        end
      end
      RESP:    drop_d = 1'b0;
      default: drop_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_IF;
      drop_q   <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      ird_q    <= '0;
      drd_q    <= '0;
      iv_q     <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      ird_q    <= ird_d;
      drd_q    <= drd_d;
      iv_q     <= iv_d;
      dv_q     <= dv_d;
    end
  end

  assign bus.mem_req   = mreq_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_be    = mbe_q;
  assign bus.if_rdata  = ird_q;
  assign bus.if_valid  = iv_q;
  assign bus.d_rdata   = drd_q;
  assign bus.d_valid   = dv_q;

  // Stalls are masked in reset so every output reads 0 there.
  assign bus.if_stall = bus.if_req & ~iv_q & ~rst;
  assign bus.d_stall  = bus.d_req & ~dv_q & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data, flush,
// fairness, reset and stale-ack scenarios.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req && n < 20);
    if (!bus.mem_req)
      chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic ack(input logic [31:0] rd);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.flush     = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_mreq", 64'(bus.mem_req), 64'd0);
    chk("rst_ival", 64'(bus.if_valid), 64'd0);
    chk("rst_dval", 64'(bus.d_valid), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // lone fetch, ack 3 cycles after mem_req
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    @(negedge clk);
    chk("f_mreq", 64'(bus.mem_req), 64'd1);
    chk("f_addr", 64'(bus.mem_addr), 64'h40);
    chk("f_we", 64'(bus.mem_we), 64'd0);
    chk("f_be", 64'(bus.mem_be), 64'hF);
    chk("f_stall", 64'(bus.if_stall), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("f_hold", 64'(bus.mem_req), 64'd1);
      chk("f_noval", 64'(bus.if_valid), 64'd0);
    end
    @(negedge clk);
    ack(32'h00500093);
    chk("f_val", 64'(bus.if_valid), 64'd1);
    chk("f_rdata", 64'(bus.if_rdata), 64'h00500093);
    chk("f_mreq0", 64'(bus.mem_req), 64'd0);
    chk("f_stall0", 64'(bus.if_stall), 64'd0);
    chk("f_dval", 64'(bus.d_valid), 64'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("f_pulse", 64'(bus.if_valid), 64'd0);

    // simultaneous store + fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'hF;
    @(negedge clk);
    chk("s_mreq", 64'(bus.mem_req), 64'd1);
    chk("s_we", 64'(bus.mem_we), 64'd1);
    chk("s_addr", 64'(bus.mem_addr), 64'h100);
    chk("s_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
    chk("s_dstall", 64'(bus.d_stall), 64'd1);
    ack(32'h0);
    chk("s_dval", 64'(bus.d_valid), 64'd1);
    chk("s_ival", 64'(bus.if_valid), 64'd0);
    chk("s_dstall0", 64'(bus.d_stall), 64'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk("s_idle", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    chk("s_fgnt", 64'(bus.mem_req), 64'd1);
    chk("s_faddr", 64'(bus.mem_addr), 64'h44);
    chk("s_fwe", 64'(bus.mem_we), 64'd0);
    ack(32'h11111111);
    chk("s_fval", 64'(bus.if_valid), 64'd1);
    bus.if_req = 1'b0;
    @(negedge clk);

    // flush one cycle into a fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h60;
    @(negedge clk);
    chk("fl_mreq", 64'(bus.mem_req), 64'd1);
    bus.flush  = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl_hold", 64'(bus.mem_req), 64'd1);
    @(negedge clk);
    ack(32'hBADBAD00);
    chk("fl_noval", 64'(bus.if_valid), 64'd0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    @(negedge clk);
    chk("fl_noval2", 64'(bus.if_valid), 64'd0);
    wait_req("fl_next");
    chk("fl_addr", 64'(bus.mem_addr), 64'h80);
    ack(32'h00A00113);
    chk("fl_val", 64'(bus.if_valid), 64'd1);
    chk("fl_rdata", 64'(bus.if_rdata), 64'h00A00113);

    // continuous load + fetch pressure
    bus.if_addr = 32'h90;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h200;
    for (int i = 0; i < 6; i++) begin
      logic exp_f;
`ifdef ARB_FAIR_EN
      exp_f = (i % 3 == 2);
`else
      exp_f = 1'b0;
`endif
      wait_req($sformatf("fair%0d", i));
      chk($sformatf("fair%0d_addr", i),
          64'(bus.mem_addr),
          exp_f ? 64'h90 : 64'h200);
      ack(32'h1000 + 32'(i));
      chk($sformatf("fair%0d_iv", i),
          64'(bus.if_valid), 64'(exp_f));
      chk($sformatf("fair%0d_dv", i),
          64'(bus.d_valid), 64'(!exp_f));
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset mid-data
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h300;
    bus.d_wdata = 32'hCAFEF00D;
    bus.d_be    = 4'h3;
    @(negedge clk);
    chk("r_mreq", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("r_mreq0", 64'(bus.mem_req), 64'd0);
    chk("r_we0", 64'(bus.mem_we), 64'd0);
    chk("r_addr0", 64'(bus.mem_addr), 64'd0);
    chk("r_be0", 64'(bus.mem_be), 64'd0);
    chk("r_dstall0", 64'(bus.d_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r_idle", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    chk("r_gnt", 64'(bus.mem_req), 64'd1);
    chk("r_addr", 64'(bus.mem_addr), 64'h300);
    chk("r_be", 64'(bus.mem_be), 64'h3);
    ack(32'h0);
    chk("r_dval", 64'(bus.d_valid), 64'd1);
    bus.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // stale ack in idle
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("st_iv", 64'(bus.if_valid), 64'd0);
    chk("st_dv", 64'(bus.d_valid), 64'd0);
    chk("st_mreq", 64'(bus.mem_req), 64'd0);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h400;
    @(negedge clk);
    chk("st_gnt", 64'(bus.mem_req), 64'd1);
    chk("st_addr", 64'(bus.mem_addr), 64'h400);
    ack(32'h12345678);
    chk("st_dv2", 64'(bus.d_valid), 64'd1);
    chk("st_rdata", 64'(bus.d_rdata), 64'h12345678);
    bus.d_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Serialises their accesses, tracks which requester owns the memory, and returns the response to that requester.
- Generates stall signals for the pipeline.
- Accepts the branch-mispredict flush so that a fetch already issued to memory is discarded.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, number of consecutive data grants allowed while a fetch waits (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched instruction; meaningful while if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_valid.
- flush  in  1  mispredict flush; kills the current or pending fetch.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data; meaningful while d_valid.
- d_valid  out  1  one-cycle data completion pulse.
- d_stall  out  1  d_req & ~d_valid.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States are IDLE, FETCH, DATA and RESP. Reset state is IDLE.
- Reset values: all outputs 0; drop flag 0; streak counter 0.
- Reset mid-transaction abandons the transaction; the memory is reset in the same domain.
- IDLE:
  - Arbitrate among if_req, d_req and flush.
  - d_req wins over if_req, because the MEM-stage instruction is older.
  - If flush=1, if_req is ignored that cycle.
  - Winner's address, data, byte enables and we are registered onto the mem_* outputs.
  - mem_req=1 from the next cycle; go to FETCH or DATA.
  - A fetch grant drives mem_we=0 and mem_be=all-ones.
- FETCH / DATA:
  - Hold mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack: register mem_rdata to the owner's rdata, drop mem_req, go to RESP.
- RESP (one cycle):
  - Pulse the owner's valid: if_valid, or d_valid.
  - Ignore all requests in this cycle, so a stale req is never re-granted.
  - Return to IDLE.
- Latency:
  - Request seen in cycle 0 → mem_req=1 in cycle 1.
  - mem_ack in cycle k (k≥1) → valid pulse in cycle k+1.
  - Next grant is evaluated no earlier than cycle k+2.
  - Minimum is 2 cycles request-to-valid; throughput is one access per 3 cycles.
- Flush during FETCH, or in the same cycle as the FETCH grant:
  - Set the drop flag.
  - Still wait for mem_ack, because a memory access cannot be aborted.
  - RESP then produces no if_valid.
  - Clear the drop flag on leaving RESP.
- Flush during DATA or RESP(data): no effect on the data access.
- mem_ack outside FETCH/DATA is ignored.
- if_valid and d_valid are never high in the same cycle.
- d_stall and if_stall are combinational from the registered valids and the inputs.

Optional Feature:
- Macro: ARB_FAIR_EN.
- With the macro defined:
  - The streak counter increments on each data grant made while if_req=1.
  - It clears on any fetch grant, or when if_req=0 in IDLE.
  - When the count equals MAX_D_STREAK and if_req & ~flush, the fetch wins the next IDLE arbitration over d_req.
  - The counter saturates and does not wrap.
- Without the macro: data always has priority, and no counter is built.

Decomposition:
- Shared package arb_pkg:
  - enum arb_state_t {IDLE, FETCH, DATA, RESP}.
  - enum arb_owner_t {OWN_IF, OWN_D}.
  - Constant ARB_BE_ALL.
- Single module. No sub-module is warranted; the streak counter is inline under the macro.

Test Plan:
- Lone fetch:
  - Stimulus: if_req=1, if_addr=0x40; memory acks 3 cycles after mem_req with rdata=0x00500093.
  - Required: mem_addr=0x40, mem_we=0; if_valid pulses once with if_rdata=0x00500093; if_stall high until then.
- Simultaneous requests:
  - Stimulus: if_req and d_req both rise in cycle 0; store with d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF.
  - Required: data is granted first (mem_we=1, mem_addr=0x100); the fetch is granted in the IDLE that follows RESP.
- Flush:
  - Stimulus: assert flush 1 cycle into a FETCH; mem_ack arrives 2 cycles later.
  - Required: no if_valid; next fetch from if_addr=0x80 completes normally.
- Fairness with ARB_FAIR_EN and MAX_D_STREAK=2:
  - Stimulus: continuous d_req and if_req.
  - Required: grant order D, D, F, D, D, F.
  - Without the macro: D only, until d_req drops.
- Reset:
  - Stimulus: assert rst mid-DATA, with mem_req=1.
  - Required: all outputs 0 immediately, asynchronously; after release the state is IDLE and the next request is served normally.
- Stale ack:
  - Stimulus: mem_ack pulses in IDLE.
  - Required: no valid pulse and no state change.
